// File: rtl/mem_controller_if.sv
// Bundles the LSU-side and memory-side buses of mem_controller.
// The master modport is the controller's view; slave is the LSUs plus memory.
interface mem_controller_if #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;
  logic [NUM_CHANNELS-1:0]            mem_read_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address;
  logic [NUM_CHANNELS-1:0]            mem_read_ready;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data;
  logic [NUM_CHANNELS-1:0]            mem_write_valid;
  logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address;
  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data;
  logic [NUM_CHANNELS-1:0]            mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/mem_controller.sv
// Arbitrates NUM_CONSUMERS LSU ports onto NUM_CHANNELS memory channels, one FSM per channel.
// MEM_CTRL_RR_EN selects round-robin arbitration; otherwise lowest consumer index wins.
module mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input logic              clk,
  input logic              reset,
  mem_controller_if.master bus
);
  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam int A  = ADDR_BITS;
  localparam int D  = DATA_BITS;

  typedef enum logic [2:0] {
    IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
  } state_t;

  state_t                 state     [NUM_CHANNELS];
  state_t                 state_nxt [NUM_CHANNELS];
  logic [IW-1:0]          idx       [NUM_CHANNELS];
  logic [IW-1:0]          idx_nxt   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] busy, busy_nxt;

  logic [NUM_CONSUMERS-1:0]   c_rd_rdy,  c_rd_rdy_nxt;
  logic [NUM_CONSUMERS*D-1:0] c_rd_data, c_rd_data_nxt;
  logic [NUM_CONSUMERS-1:0]   c_wr_rdy,  c_wr_rdy_nxt;
  logic [NUM_CHANNELS-1:0]    m_rd_vld,  m_rd_vld_nxt;
  logic [NUM_CHANNELS*A-1:0]  m_rd_addr, m_rd_addr_nxt;
  logic [NUM_CHANNELS-1:0]    m_wr_vld,  m_wr_vld_nxt;
  logic [NUM_CHANNELS*A-1:0]  m_wr_addr, m_wr_addr_nxt;
  logic [NUM_CHANNELS*D-1:0]  m_wr_data, m_wr_data_nxt;

`ifdef MEM_CTRL_RR_EN
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
`endif

  assign bus.consumer_read_ready  = c_rd_rdy;
  assign bus.consumer_read_data   = c_rd_data;
  assign bus.consumer_write_ready = c_wr_rdy;
  assign bus.mem_read_valid       = m_rd_vld;
  assign bus.mem_read_address     = m_rd_addr;
  assign bus.mem_write_valid      = m_wr_vld;
  assign bus.mem_write_address    = m_wr_addr;
  assign bus.mem_write_data       = m_wr_data;

  // claim accumulates grants as channels are scanned low-to-high, hiding a
  // consumer from later channels; release is applied only at the edge so a
  // freed consumer cannot be re-granted in the same cycle.
  logic [NUM_CONSUMERS-1:0] claim, release_mask;
  logic [IW-1:0]            sel;
  logic                     found;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    c_rd_rdy_nxt  = c_rd_rdy;
    c_rd_data_nxt = c_rd_data;
    c_wr_rdy_nxt  = c_wr_rdy;
    m_rd_vld_nxt  = m_rd_vld;
    m_rd_addr_nxt = m_rd_addr;
    m_wr_vld_nxt  = m_wr_vld;
    m_wr_addr_nxt = m_wr_addr;
    m_wr_data_nxt = m_wr_data;
    claim         = busy;
    release_mask  = '0;
    sel           = '0;
    found         = 1'b0;
`ifdef MEM_CTRL_RR_EN
    rr_ptr_nxt    = rr_ptr;
`endif
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      case (state[c])
        IDLE: begin
          found = 1'b0;
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_CTRL_RR_EN
            sel = IW'((int'(rr_ptr) + k) % NUM_CONSUMERS);
`else
            sel = IW'(k);
`endif
            if (!found && !claim[sel] &&
                (bus.consumer_read_valid[sel] || bus.consumer_write_valid[sel])) begin
              found        = 1'b1;
              claim[sel]   = 1'b1;
              idx_nxt[c]   = sel;
`ifdef MEM_CTRL_RR_EN
              rr_ptr_nxt   = IW'((int'(sel) + 1) % NUM_CONSUMERS);
`endif
              if (bus.consumer_read_valid[sel]) begin
                m_rd_vld_nxt[c]            = 1'b1;
                m_rd_addr_nxt[c*A +: A]    = bus.consumer_read_address[sel*A +: A];
                state_nxt[c]               = READ_WAITING;
              end else begin
                m_wr_vld_nxt[c]            = 1'b1;
                m_wr_addr_nxt[c*A +: A]    = bus.consumer_write_address[sel*A +: A];
                m_wr_data_nxt[c*D +: D]    = bus.consumer_write_data[sel*D +: D];
                state_nxt[c]               = WRITE_WAITING;
              end
            end
          end
        end
        READ_WAITING: if (bus.mem_read_ready[c]) begin
          m_rd_vld_nxt[c]                 = 1'b0;
          c_rd_rdy_nxt[idx[c]]            = 1'b1;
          c_rd_data_nxt[idx[c]*D +: D]    = bus.mem_read_data[c*D +: D];
          state_nxt[c]                    = READ_RELAYING;
        end
        WRITE_WAITING: if (bus.mem_write_ready[c]) begin
          m_wr_vld_nxt[c]      = 1'b0;
          c_wr_rdy_nxt[idx[c]] = 1'b1;
          state_nxt[c]         = WRITE_RELAYING;
        end
        READ_RELAYING: if (!bus.consumer_read_valid[idx[c]]) begin
          c_rd_rdy_nxt[idx[c]] = 1'b0;
          release_mask[idx[c]] = 1'b1;
          state_nxt[c]         = IDLE;
        end
        WRITE_RELAYING: if (!bus.consumer_write_valid[idx[c]]) begin
          c_wr_rdy_nxt[idx[c]] = 1'b0;
          release_mask[idx[c]] = 1'b1;
          state_nxt[c]         = IDLE;
        end
        default: state_nxt[c] = IDLE;
      endcase
    end
    busy_nxt = claim & ~release_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= IDLE;
        idx[c]   <= '0;
      end
      busy      <= '0;
      c_rd_rdy  <= '0;
      c_rd_data <= '0;
      c_wr_rdy  <= '0;
      m_rd_vld  <= '0;
      m_rd_addr <= '0;
      m_wr_vld  <= '0;
      m_wr_addr <= '0;
      m_wr_data <= '0;
`ifdef MEM_CTRL_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      c_rd_rdy  <= c_rd_rdy_nxt;
      c_rd_data <= c_rd_data_nxt;
      c_wr_rdy  <= c_wr_rdy_nxt;
      m_rd_vld  <= m_rd_vld_nxt;
      m_rd_addr <= m_rd_addr_nxt;
      m_wr_vld  <= m_wr_vld_nxt;
      m_wr_addr <= m_wr_addr_nxt;
      m_wr_data <= m_wr_data_nxt;
`ifdef MEM_CTRL_RR_EN
      rr_ptr    <= rr_ptr_nxt;
`endif
    end
  end
endmodule
